vx_dispatch_arb: RTL



---
 rtl/vx_dispatch_arb_pkg.sv | 29 ++
 rtl/vx_dispatch_arb_if.sv | 29 ++
 rtl/vx_dispatch_arb_skid.sv | 56 +++++
 rtl/vx_dispatch_arb.sv | 80 ++++++++
 4 files changed

// File: rtl/vx_dispatch_arb_pkg.sv
// Shared dispatch payload layout and sizing helpers for the dispatch arbiter.
// Pure declarations: no latency, no flow control.
package vx_dispatch_arb_pkg;

    typedef struct packed {
        logic [31:0] uuid;
        logic [7:0]  wid;
        logic [31:0] tmask;
        logic [31:0] pc;
        logic [7:0]  op_type;
        logic [15:0] op_args;
        logic [7:0]  wb;
        logic [7:0]  rd;
        logic [7:0]  rs1;
        logic [7:0]  rs2;
        logic [7:0]  rs3;
        logic [31:0] imm;
        logic [55:0] rsvd;
    } dispatch_data_t;

    localparam int DISPATCH_DATAW = $bits(dispatch_data_t);
    localparam int PERF_W_DEF     = 32;

    // Source index width, never narrower than one bit so NUM_REQS=1 still has a select.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_dispatch_arb_if.sv
// Requester-side and execute-side handshake bundle of the dispatch arbiter.
// slave = arbiter view, master = driver/consumer view.
interface vx_dispatch_arb_if
    import vx_dispatch_arb_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int DATAW     = DISPATCH_DATAW,
    parameter int REQ_SEL_W = sel_w(NUM_REQS),
    parameter int PERF_W    = PERF_W_DEF
);
    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS*DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]       req_ready;
    logic                      out_valid;
    logic [DATAW-1:0]          out_data;
    logic [REQ_SEL_W-1:0]      out_sel;
    logic                      out_ready;
    logic [PERF_W-1:0]         perf_stalls;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_sel, perf_stalls
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_sel, perf_stalls
    );
endinterface

// File: rtl/vx_dispatch_arb_skid.sv
// Two-entry payload+source buffer; 1 cycle from push to out_valid, full-rate when streaming.
// in_ready is purely registered (count<2), so a pop never re-opens the input in the same cycle.
module vx_dispatch_arb_skid #(
    parameter int DATAW = 256,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);
    logic [DATAW-1:0] data_q [2];
    logic [SEL_W-1:0] sel_q  [2];
    logic             head, tail;
    logic [1:0]       count;
    logic             push, pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = data_q[head];
    assign out_sel   = sel_q[head];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                sel_q[i]  <= '0;
            end
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                data_q[tail] <= in_data;
                sel_q[tail]  <= in_sel;
                tail         <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vx_dispatch_arb.sv
// Round-robin share of one execute dispatch port between NUM_REQS streams; 1 cycle accept->out_valid.
// Requesters see ready only while the output buffer has room; ready never looks at out_ready.
module vx_dispatch_arb
    import vx_dispatch_arb_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int DATAW     = DISPATCH_DATAW,
    parameter int REQ_SEL_W = sel_w(NUM_REQS),
    parameter int PERF_W    = PERF_W_DEF
) (
    input logic               clk,
    input logic               reset,
    vx_dispatch_arb_if.slave  bus
);
    localparam logic [REQ_SEL_W-1:0] LAST_REQ = REQ_SEL_W'(NUM_REQS - 1);

    logic [REQ_SEL_W-1:0] rr_ptr;
    logic [REQ_SEL_W-1:0] grant;
    logic                 any_valid;
    logic                 skid_ready;
    logic                 accept;
    logic [DATAW-1:0]     grant_data;
    logic [PERF_W-1:0]    stalls;

    // Scan from the pointer upward with wrap; descending loop lets the nearest hit win.
    function automatic logic [REQ_SEL_W-1:0] pick(input logic [NUM_REQS-1:0] v,
                                                  input logic [REQ_SEL_W-1:0] p);
        int                  idx;
        logic [NUM_REQS-1:0] sh;
        pick = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_REQS;
            sh  = v >> idx;
            if (sh[0]) pick = idx[REQ_SEL_W-1:0];
        end
    endfunction

    assign any_valid     = |bus.req_valid;
    assign grant         = pick(bus.req_valid, rr_ptr);
    assign accept        = any_valid && skid_ready;
    assign bus.req_ready = accept ? (NUM_REQS'(1) << grant) : '0;
    assign bus.perf_stalls = stalls;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant == REQ_SEL_W'(i)) grant_data = bus.req_data[i*DATAW +: DATAW];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            stalls <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= (grant == LAST_REQ) ? '0 : grant + REQ_SEL_W'(1);
            end
            if (any_valid && !accept) begin
                stalls <= stalls + PERF_W'(1);
            end
        end
    end

    vx_dispatch_arb_skid #(
        .DATAW (DATAW),
        .SEL_W (REQ_SEL_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (any_valid),
        .in_data   (grant_data),
        .in_sel    (grant),
        .in_ready  (skid_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_sel   (bus.out_sel),
        .out_ready (bus.out_ready)
    );
endmodule
